// File: rtl/dbf_fine_interp.sv
// Fine-delay linear interpolator: per-sample 3-bit phase from a LUT blends x_prev and x_n in 1/8 steps.
// Optional macro DBF_FD_RND_EN adds round-half-up (R=4) before the final shift; default truncates.
module dbf_fine_interp #(
    parameter int INPUT_WD  = 14,
    parameter int ADDR_WD   = 10,
    parameter int FD_OUT_WD = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_en,
    input  logic                        start,
    input  logic [ADDR_WD-1:0]          lut_addr,
    input  logic                        lut_we,
    input  logic [2:0]                  lut_din,
    input  logic signed [INPUT_WD-1:0]  fine_din,
    input  logic                        fine_din_valid,
    output logic signed [FD_OUT_WD-1:0] fine_dout,
    output logic                        fine_dout_valid,
    output logic                        line_done
);

    localparam int SUM_WD = INPUT_WD + 4;
    localparam int EXT_WD = (FD_OUT_WD > SUM_WD) ? FD_OUT_WD : SUM_WD;
    localparam logic [ADDR_WD-1:0] CNT_MAX = {ADDR_WD{1'b1}};
`ifdef DBF_FD_RND_EN
    localparam logic signed [EXT_WD-1:0] RND = EXT_WD'(4);
`else
    localparam logic signed [EXT_WD-1:0] RND = EXT_WD'(0);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [2:0] lut_mem_q [2**ADDR_WD];

    state_t                      state_q, state_d;
    logic                        start_q, start_d;
    logic [ADDR_WD-1:0]          cnt_q, cnt_d;
    logic signed [INPUT_WD-1:0]  x_prev_q, x_prev_d;
    logic                        v1_q, v1_d, last1_q, last1_d;
    logic [2:0]                  p1_q, p1_d;
    logic signed [INPUT_WD-1:0]  xp1_q, xp1_d, xn1_q, xn1_d;
    logic                        v2_q, v2_d, last2_q, last2_d;
    logic signed [SUM_WD-1:0]    pa2_q, pa2_d, pb2_q, pb2_d;
    logic signed [FD_OUT_WD-1:0] dout_q, dout_d;
    logic                        dout_valid_q, dout_valid_d;
    logic                        line_done_q, line_done_d;

    logic                        flush_s, accept_s, last_s;
    logic [3:0]                  wa_s;
    logic signed [EXT_WD-1:0]    sum_s, shifted_s;

    // LUT write port; contents survive reset, a same-edge read sees the old entry
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem_q[lut_addr] <= lut_din;
        end
    end

    // Line control FSM plus the three-stage datapath next-state logic
    always_comb begin
        state_d  = state_q;
        start_d  = start;
        cnt_d    = cnt_q;
        x_prev_d = x_prev_q;
        flush_s  = 1'b0;
        accept_s = 1'b0;
        last_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !start_q) begin
                    state_d  = ST_PRIME;
                    cnt_d    = '0;
                    x_prev_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (fine_din_valid) begin
                    x_prev_d = fine_din;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (fine_din_valid) begin
                    accept_s = 1'b1;
                    x_prev_d = fine_din;
                    cnt_d    = cnt_q + ADDR_WD'(1);
                    last_s   = (cnt_q == CNT_MAX);
                    state_d  = (cnt_q == CNT_MAX) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (v2_q && last2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx_en wins over everything; losing start mid-line aborts the same way
        if (tx_en || (!start && (state_q == ST_PRIME || state_q == ST_RUN))) begin
            flush_s  = 1'b1;
            accept_s = 1'b0;
            last_s   = 1'b0;
            state_d  = ST_IDLE;
        end else begin
            flush_s = 1'b0;
        end

        v1_d    = accept_s;
        last1_d = last_s;
        p1_d    = lut_mem_q[cnt_q];
        xp1_d   = x_prev_q;
        xn1_d   = fine_din;

        wa_s    = 4'd8 - {1'b0, p1_q};
        v2_d    = v1_q && !flush_s;
        last2_d = last1_q && !flush_s;
        pa2_d   = SUM_WD'(xp1_q) * SUM_WD'($signed({1'b0, wa_s}));
        pb2_d   = SUM_WD'(xn1_q) * SUM_WD'($signed({2'b00, p1_q}));

        sum_s        = EXT_WD'(pa2_q) + EXT_WD'(pb2_q) + RND;
        shifted_s    = sum_s >>> 3;
        dout_valid_d = v2_q && !flush_s;
        line_done_d  = v2_q && last2_q && !flush_s;
        dout_d       = dout_valid_d ? shifted_s[FD_OUT_WD-1:0] : '0;
    end

    // State and pipeline registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            cnt_q        <= '0;
            x_prev_q     <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            p1_q         <= 3'd0;
            xp1_q        <= '0;
            xn1_q        <= '0;
            v2_q         <= 1'b0;
            last2_q      <= 1'b0;
            pa2_q        <= '0;
            pb2_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            x_prev_q     <= x_prev_d;
            v1_q         <= v1_d;
            last1_q      <= last1_d;
            p1_q         <= p1_d;
            xp1_q        <= xp1_d;
            xn1_q        <= xn1_d;
            v2_q         <= v2_d;
            last2_q      <= last2_d;
            pa2_q        <= pa2_d;
            pb2_q        <= pb2_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            line_done_q  <= line_done_d;
        end
    end

    assign fine_dout       = dout_q;
    assign fine_dout_valid = dout_valid_q;
    assign line_done       = line_done_q;

endmodule

// File: tb/tb_dbf_fine_interp.sv
// Scoreboard bench for dbf_fine_interp (ADDR_WD=4): randomized lines against a behavioural model.
module tb_dbf_fine_interp;

    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              tx_en = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        lut_addr = 4'd0;
    logic              lut_we = 1'b0;
    logic [2:0]        lut_din = 3'd0;
    logic signed [13:0] fine_din = 14'sd0;
    logic              fine_din_valid = 1'b0;
    logic signed [15:0] fine_dout;
    logic              fine_dout_valid;
    logic              line_done;

    dbf_fine_interp #(.INPUT_WD(14), .ADDR_WD(4), .FD_OUT_WD(16)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
        .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
        .fine_din(fine_din), .fine_din_valid(fine_din_valid),
        .fine_dout(fine_dout), .fine_dout_valid(fine_dout_valid), .line_done(line_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int y; bit ld; int cyc; } exp_t;
    exp_t sb_q[$];
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    // behavioural model state: 0 idle, 1 priming, 2 running, 3 line complete
    int m_state = 0;
    bit m_prev_start = 1'b0;
    int m_cnt = 0;
    int m_xprev = 0;
    int m_lut [DEPTH];
    bit st_lvl = 1'b0;
`ifdef DBF_FD_RND_EN
    localparam int R = 4;
`else
    localparam int R = 0;
`endif

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int floor_div8(input int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    function automatic void model_flush();
        while (sb_q.size() > 0 && sb_q[$].cyc > cyc) void'(sb_q.pop_back());
    endfunction

    task automatic step(input bit r, input bit tx, input bit st, input bit v, input int x,
                        input bit we, input int a, input int d);
        int p;
        exp_t e;
        rst_n = r; tx_en = tx; start = st; fine_din_valid = v; fine_din = x[13:0];
        lut_we = we; lut_addr = a[3:0]; lut_din = d[2:0];
        st_lvl = st;
        if (r) begin
            model_flush(); m_state = 0; m_prev_start = 1'b0;
        end else begin
            if (tx) begin
                model_flush(); m_state = 0;
            end else begin
                case (m_state)
                    0: if (st && !m_prev_start) begin m_state = 1; m_cnt = 0; end
                    1: if (!st) begin model_flush(); m_state = 0; end
                       else if (v) begin m_xprev = x; m_state = 2; end
                    2: if (!st) begin model_flush(); m_state = 0; end
                       else if (v) begin
                           p = m_lut[m_cnt];
                           e.y = floor_div8((8 - p) * m_xprev + p * x + R);
                           e.ld = (m_cnt == DEPTH - 1);
                           e.cyc = cyc + 3;
                           sb_q.push_back(e);
                           m_xprev = x;
                           m_cnt++;
                           if (m_cnt == DEPTH) begin m_cnt = 0; m_state = 3; end
                       end
                    default: m_state = 0;
                endcase
            end
            m_prev_start = st;
        end
        if (we) m_lut[a] = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, st_lvl, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic samp(input int x);
        step(1'b0, 1'b0, 1'b1, 1'b1, x, 1'b0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        step(1'b0, 1'b0, st_lvl, 1'b0, 0, 1'b1, a, d);
    endtask

    task automatic begin_line();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 40) begin idle(1); n++; end
        total++;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        idle(2);
    endtask

    task automatic rand_line(input bit gaps, input bit collide);
        int n = 0;
        bit v;
        int x;
        while ((m_state == 1 || m_state == 2) && n < 200) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            x = int'($urandom_range(0, 16382)) - 8191;
            if (collide && m_state == 2 && n[0])
                step(1'b0, 1'b0, 1'b1, v, x, 1'b1, m_cnt, int'($urandom_range(0, 7)));
            else
                step(1'b0, 1'b0, 1'b1, v, x, 1'b0, 0, 0);
            n++;
        end
    endtask

    // monitor: pop and compare on every valid output, require zeros otherwise
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (fine_dout_valid) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got %0d with nothing expected", fine_dout);
                end else begin
                    e = sb_q.pop_front();
                    chk("dout", int'(fine_dout), e.y);
                    chk("line_done", int'(line_done), int'(e.ld));
                    chk("latency_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_dout_zero", int'(fine_dout), 0);
                chk("idle_line_done", int'(line_done), 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        chk("rst_dout", int'(fine_dout), 0);
        chk("rst_valid", int'(fine_dout_valid), 0);
        chk("rst_line_done", int'(line_done), 0);
        mon_en = 1'b1;

        // all phases zero: output equals the previous sample
        for (int a = 0; a < DEPTH; a++) wr(a, 0);
        begin_line(); samp(100); samp(200); samp(300); drain();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);

        // half-sample phase and full-scale signed extremes
        wr(0, 4);
        begin_line(); samp(100); samp(101); drain();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        wr(0, 3);
        begin_line(); samp(-8191); samp(8191); drain();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);

        // random LUT; complete lines with gaps, then back-to-back with same-address writes
        for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(0, 7)));
        begin_line(); rand_line(1'b1, 1'b0); drain();
        begin_line(); rand_line(1'b0, 1'b1); drain();
        idle(3);

        // tx_en mid-line with samples in flight
        begin_line();
        for (int i = 0; i < 6; i++) samp(int'($urandom_range(0, 16382)) - 8191);
        step(1'b0, 1'b1, 1'b1, 1'b1, 77, 1'b0, 0, 0);
        chk("tx_dout_zero", int'(fine_dout), 0);
        chk("tx_valid_zero", int'(fine_dout_valid), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(5); drain();

        // start dropped mid-line
        begin_line();
        for (int i = 0; i < 6; i++) samp(int'($urandom_range(0, 16382)) - 8191);
        step(1'b0, 1'b0, 1'b0, 1'b1, 55, 1'b0, 0, 0);
        idle(5); drain();

        // reset mid-line; LUT must survive for the following line
        begin_line();
        for (int i = 0; i < 6; i++) samp(int'($urandom_range(0, 16382)) - 8191);
        step(1'b1, 1'b0, 1'b0, 1'b1, 99, 1'b0, 0, 0);
        chk("midrst_dout", int'(fine_dout), 0);
        chk("midrst_valid", int'(fine_dout_valid), 0);
        chk("midrst_line_done", int'(line_done), 0);
        idle(2);
        begin_line(); rand_line(1'b1, 1'b0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
